thinning_pass_scheduler: RTL
============================

# thinning_pass_scheduler

Sequences the skeletonization datapath around the shared image RAM write port. It admits an N×N frame from the external loader. It then runs alternating thinning sub-iterations by granting the center mask's write-back requests until a full pass changes no pixel or a pass limit is hit. It optionally finishes with one Harris-corner scan. It drives the RAM write enable, the write address and the write-data select that the write controller uses.

## Interface
- N, 8, image side length; frame = N*N pixels
- bitSize, 6, address MSB index; addresses are [bitSize:0], and N*N ≤ 2^(bitSize+1)
- pixelWidth, 8, pixel width; carried for interface consistency, no pixel data passes through this block
- MAX_PASSES, 16, full-pass limit (≥1)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  external pixel strobe
- load_ready  out  1  frame load accepted this cycle
- start  in  1  command pulse: begin thinning (READY) or begin new frame (DONE)
- mask_req  in  1  center mask requests one pixel write-back
- mask_changed  in  1  written pixel differs from stored value; qualified by mask_req
- mask_grant  out  1  write-back accepted this cycle
- mask_en  out  1  center mask may scan/request
- sub_iter  out  1  current thinning sub-iteration (0/1)
- harris_en  out  1  Harris scan phase; selects Harris memory
- mem_we  out  1  RAM write enable
- mem_addr  out  bitSize+1  RAM primary write address
- wr_sel  out  1  0 = external data, 1 = mask write-back
- pass_count  out  $clog2(MAX_PASSES+1)  completed full passes
- busy  out  1  SCAN/PASS_END/HARRIS
- done  out  1  high in DONE

## Operation
- States: LOAD (reset state), READY, SCAN, PASS_END, HARRIS, DONE.
- LOAD:
  - load_ready=1. Each load_valid cycle gives mem_we=1, wr_sel=0, mem_addr=addr, then addr++.
  - The N*N-th write sets addr←0 and moves to READY.
- READY: start → SCAN with sub_iter=0 and the changed flag cleared.
- SCAN:
  - mask_en=1 and mask_grant=mask_req. On a grant, mem_we=1, wr_sel=1, then addr++.
  - mask_req&mask_changed sets the sticky changed flag.
  - The N*N-th grant sets addr←0 and moves to PASS_END.
- PASS_END (exactly 1 cycle, mask_en=0, no grants):
  - sub_iter=0 → set sub_iter=1, return to SCAN. The flag is kept.
  - sub_iter=1 → pass_count++, sub_iter←0.
  - If the flag is clear or pass_count+1==MAX_PASSES → HARRIS (macro on) or DONE. Otherwise clear the flag and return to SCAN.
- HARRIS: harris_en=1, mask_en=1. Grant and write rules match SCAN; mask_changed is ignored. The N*N-th grant → DONE.
- DONE:
  - done=1; pass_count is held.
  - start → LOAD, which clears pass_count, addr, sub_iter and the flag.
- Ignored inputs:
  - load_valid outside LOAD (load_ready=0).
  - mask_req outside SCAN/HARRIS (grant=0, no write).
  - start outside READY/DONE.
- Address arithmetic: addr counts 0..N*N-1 only. The terminal count resets it to 0, never to a natural power-of-two wrap.

## Timing
- State, addr, sub_iter, flag and pass_count are registered.
- mem_we, mem_addr, wr_sel, mask_grant and load_ready are combinational from state, addr and inputs (zero latency). A write lands on the same edge it is requested.
- Reset values: state LOAD, addr 0, pass_count 0, sub_iter 0, flag 0. Outputs: load_ready=1 and all others 0.
- rst mid-frame or mid-pass returns to LOAD next edge. Partial RAM contents are undefined and no write is issued in the reset cycle.
- With mask_req held high, one sub-iteration = N*N cycles plus 1 PASS_END cycle, so a full pass = 2·N*N+2 cycles.
- Same-cycle mask_req+mask_changed on the terminal grant is counted in that sub-iteration.

## Configuration
- HARRIS_PASS_EN defined: HARRIS state exists and runs after convergence or the pass limit.
- Undefined: HARRIS state is omitted, harris_en is tied 0, and PASS_END goes directly to DONE.

## Structure
- Shared package thinning_pkg:
  - state enum typedef
  - wr_sel constants WR_SEL_EXT=0, WR_SEL_MASK=1
- Sub-module pixel_addr_counter: clear, enable, parameterized terminal count N*N, outputs addr and a terminal flag. It is used for the addr register.

## Test plan
- Reset, then 64 load_valid cycles with N=8 → addresses 0..63 written with wr_sel=0; READY after the 64th; load_ready=0 afterwards.
- start, mask_req high, mask_changed never → two sub-iterations (128 grants, 2 PASS_END cycles), pass_count=1, then DONE (or HARRIS+64 grants with macro).
- mask_changed pulsed once in every pass, MAX_PASSES=3 → stops with pass_count=3 after 3·130 cycles of continuous requests.
- mask_req toggled every other cycle → addr advances only on grants; the sub-iteration ends exactly at the 64th grant.
- rst asserted at grant 30 of SCAN → next cycle state LOAD, addr 0, pass_count 0, mem_we 0.
- load_valid and start asserted during SCAN → ignored; the load address is unaffected and no extra writes occur.

Source files
------------

// File: rtl/thinning_pkg.sv
// Shared types for the thinning pass scheduler: FSM state encoding and
// the write-data select codes consumed by the RAM write controller.
package thinning_pkg;

  typedef enum logic [2:0] {
    LOAD,
    READY,
    SCAN,
    PASS_END,
    HARRIS,
    DONE
  } state_t;

  localparam logic WR_SEL_EXT  = 1'b0;
  localparam logic WR_SEL_MASK = 1'b1;

endpackage

// File: rtl/pixel_addr_counter.sv
// Pixel address counter: counts 0..TERM-1 and wraps to 0 on the terminal
// count (never a power-of-two wrap); clear and rst both force 0.
module pixel_addr_counter #(
  parameter int TERM = 64,
  parameter int W    = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] addr,
  output logic         last
);

  assign last = (addr == W'(TERM - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      addr <= '0;
    end else if (en) begin
      addr <= last ? '0 : addr + W'(1);
    end
  end

endmodule

// File: rtl/thinning_pass_scheduler.sv
// Schedules frame load, alternating thinning sub-iterations and the
// optional Harris scan (enabled by defining HARRIS_PASS_EN) on the RAM write port.
module thinning_pass_scheduler
  import thinning_pkg::*;
#(
  parameter int N          = 8,
  parameter int bitSize    = 6,
  parameter int pixelWidth = 8,
  parameter int MAX_PASSES = 16,
  localparam int PCW       = $clog2(MAX_PASSES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             start,
  input  logic             mask_req,
  input  logic             mask_changed,
  output logic             mask_grant,
  output logic             mask_en,
  output logic             sub_iter,
  output logic             harris_en,
  output logic             mem_we,
  output logic [bitSize:0] mem_addr,
  output logic             wr_sel,
  output logic [PCW-1:0]   pass_count,
  output logic             busy,
  output logic             done,
  output state_t           state_dbg
);

  localparam logic [PCW-1:0] LAST_PASS = PCW'(MAX_PASSES - 1);

  if (N * N > 2 ** (bitSize + 1) || MAX_PASSES < 1 || pixelWidth < 1) begin : g_bad_cfg
    $error("thinning_pass_scheduler: inconsistent parameters");
  end

  state_t           state, state_n;
  logic             sub_iter_n, flag, flag_n;
  logic [PCW-1:0]   pass_n;
  logic             cnt_en, cnt_clr, cnt_last;
  logic [bitSize:0] addr;
  logic             harris_c;

  pixel_addr_counter #(.TERM(N * N), .W(bitSize + 1)) u_addr (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clr),
    .en   (cnt_en),
    .addr (addr),
    .last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      sub_iter   <= 1'b0;
      flag       <= 1'b0;
      pass_count <= '0;
    end else begin
      state      <= state_n;
      sub_iter   <= sub_iter_n;
      flag       <= flag_n;
      pass_count <= pass_n;
    end
  end

  // Handshakes: a transfer (one RAM write) occurs in any cycle where
  // load_valid&load_ready or mask_req&mask_grant; ready/grant never wait.
  always_comb begin
    state_n    = state;
    sub_iter_n = sub_iter;
    flag_n     = flag;
    pass_n     = pass_count;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    load_ready = 1'b0;
    mask_en    = 1'b0;
    mask_grant = 1'b0;
    harris_c   = 1'b0;
    mem_we     = 1'b0;
    wr_sel     = WR_SEL_EXT;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mem_we = 1'b1;
          cnt_en = 1'b1;
          if (cnt_last) state_n = READY;
        end
      end
      READY: begin
        if (start) begin
          state_n    = SCAN;
          sub_iter_n = 1'b0;
          flag_n     = 1'b0;
        end
      end
      SCAN: begin
        busy       = 1'b1;
        mask_en    = 1'b1;
        mask_grant = mask_req;
        if (mask_req) begin
          mem_we = 1'b1;
          wr_sel = WR_SEL_MASK;
          cnt_en = 1'b1;
          if (mask_changed) flag_n = 1'b1;
          if (cnt_last) state_n = PASS_END;
        end
      end
      PASS_END: begin
        busy = 1'b1;
        if (!sub_iter) begin
          sub_iter_n = 1'b1;
          state_n    = SCAN;
        end else begin
          pass_n     = pass_count + PCW'(1);
          sub_iter_n = 1'b0;
          if (!flag || pass_count == LAST_PASS) begin
`ifdef HARRIS_PASS_EN
            state_n = HARRIS;
`else
            state_n = DONE;
`endif
          end else begin
            flag_n  = 1'b0;
            state_n = SCAN;
          end
        end
      end
`ifdef HARRIS_PASS_EN
      HARRIS: begin
        busy       = 1'b1;
        harris_c   = 1'b1;
        mask_en    = 1'b1;
        mask_grant = mask_req;
        if (mask_req) begin
          mem_we = 1'b1;
          wr_sel = WR_SEL_MASK;
          cnt_en = 1'b1;
          if (cnt_last) state_n = DONE;
        end
      end
`endif
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_n    = LOAD;
          pass_n     = '0;
          sub_iter_n = 1'b0;
          flag_n     = 1'b0;
          cnt_clr    = 1'b1;
        end
      end
      default: state_n = LOAD;
    endcase
    // A reset cycle must never write, whatever state it interrupts.
    if (rst) begin
      load_ready = 1'b1;
      mask_en    = 1'b0;
      mask_grant = 1'b0;
      harris_c   = 1'b0;
      mem_we     = 1'b0;
      wr_sel     = WR_SEL_EXT;
      busy       = 1'b0;
      done       = 1'b0;
    end
  end

`ifdef HARRIS_PASS_EN
  assign harris_en = harris_c;
`else
  assign harris_en = 1'b0;
`endif

  assign mem_addr  = addr;
  assign state_dbg = state;

endmodule
